// File: rtl/com_slink_pkt_check_pkg.sv
// Shared SLINK definitions for the receive packet checker: CRC constants,
// FSM state encoding and status timing.
package com_slink_pkt_check_pkg;

  localparam logic [15:0] CRC16_POLY   = 16'h1021;
  localparam logic [15:0] CRC16_INIT   = 16'h0000;
  localparam logic [10:0] BYTE_CNT_MAX = 11'h7FF;
  localparam int unsigned STATUS_LAT   = 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } slink_state_e;

endpackage

// File: rtl/com_slink_crc16_d8.sv
// Combinational CRC-16 (poly 0x1021, MSB first) update for one data byte.
module com_slink_crc16_d8
  import com_slink_pkt_check_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_v;
  logic        fb_v;

  // Shift the byte through the LFSR one bit at a time, MSB first.
  always_comb begin
    crc_v = crc_i;
    fb_v  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      fb_v  = crc_v[15] ^ data_i[i];
      crc_v = {crc_v[14:0], 1'b0} ^ (fb_v ? CRC16_POLY : 16'h0000);
    end
    crc_o = crc_v;
  end

endmodule

// File: rtl/com_slink_pkt_check.sv
// Per-channel SLINK RX packet checker: frames packets and reports length,
// CRC and tick-continuity status plus a delay-timeout level.
module com_slink_pkt_check
  import com_slink_pkt_check_pkg::*;
#(
  parameter logic [10:0] PKT_LEN       = 11'd64,
  parameter logic [23:0] DELAY_TIMEOUT = 24'd125000
) (
  input  logic       clk_125m,
  input  logic       rst_125m,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_sop,
  input  logic       rx_eop,
  output logic       chn_pkt_eop,
  output logic       chn_pkt_len_err,
  output logic       chn_pkt_tick_err,
  output logic       chn_pkt_crc_err,
  output logic       chn_pkt_delay_err,
  output logic [7:0] rx_pkt_tick
);

  slink_state_e state_q, state_d;
  logic [10:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0]  crc_q, crc_d;
  logic [7:0]   tick_q, tick_d;
  logic [7:0]   last_tick_q, last_tick_d;
  logic         tick_vld_q, tick_vld_d;
  logic [7:0]   rx_tick_q, rx_tick_d;
  logic [23:0]  dly_cnt_q, dly_cnt_d;
  logic         delay_err_q, delay_err_d;
  logic         pkt_eop_q, pkt_eop_d;
  logic         len_err_q, len_err_d;
  logic         tick_err_q, tick_err_d;
  logic         crc_err_q, crc_err_d;

  logic [15:0]  crc_in_s, crc_nxt_s;
  logic [10:0]  cnt_inc_s, fin_cnt_s;
  logic [7:0]   fin_tick_s;
  logic         end_s, abort_s, len_bad_s, crc_bad_s, tick_bad_s, tick_vld_upd_s;

  // A sop byte always restarts the CRC, whether from IDLE or as an abort.
  assign crc_in_s  = rx_sop ? CRC16_INIT : crc_q;
  assign cnt_inc_s = (byte_cnt_q == BYTE_CNT_MAX) ? BYTE_CNT_MAX : byte_cnt_q + 11'd1;

  com_slink_crc16_d8 u_crc (
    .crc_i  (crc_in_s),
    .data_i (rx_data),
    .crc_o  (crc_nxt_s)
  );

  // Framing FSM, packet status evaluation and delay timer next-state.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    crc_d       = crc_q;
    tick_d      = tick_q;
    last_tick_d = last_tick_q;
    rx_tick_d   = rx_tick_q;
    end_s       = 1'b0;
    abort_s     = 1'b0;
    fin_cnt_s   = 11'd0;
    fin_tick_s  = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && rx_sop) begin
          crc_d      = crc_nxt_s;
          byte_cnt_d = 11'd1;
          tick_d     = rx_data;
          if (rx_eop) begin
            end_s      = 1'b1;
            fin_cnt_s  = 11'd1;
            fin_tick_s = rx_data;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_RECV;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (rx_valid && rx_sop) begin
          abort_s    = 1'b1;
          crc_d      = crc_nxt_s;
          byte_cnt_d = 11'd1;
          tick_d     = rx_data;
          state_d    = rx_eop ? ST_IDLE : ST_RECV;
        end else if (rx_valid) begin
          crc_d      = crc_nxt_s;
          byte_cnt_d = cnt_inc_s;
          if (rx_eop) begin
            end_s      = 1'b1;
            fin_cnt_s  = cnt_inc_s;
            fin_tick_s = tick_q;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_RECV;
          end
        end else begin
          state_d = ST_RECV;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    len_bad_s  = (fin_cnt_s != PKT_LEN);
    crc_bad_s  = (crc_nxt_s != 16'h0000);
    tick_bad_s = tick_vld_q && !crc_bad_s && (fin_tick_s != last_tick_q + 8'd1);

    if (end_s) begin
      pkt_eop_d  = 1'b1;
      len_err_d  = len_bad_s;
      crc_err_d  = crc_bad_s;
      tick_err_d = tick_bad_s;
    end else begin
      pkt_eop_d  = abort_s;
      len_err_d  = abort_s;
      crc_err_d  = 1'b0;
      tick_err_d = 1'b0;
    end

    // Only clean packets advance the tick reference.
    if (end_s && !crc_bad_s && !len_bad_s) begin
      last_tick_d    = fin_tick_s;
      rx_tick_d      = fin_tick_s;
      tick_vld_upd_s = 1'b1;
    end else begin
      tick_vld_upd_s = tick_vld_q;
    end

    if (pkt_eop_d) begin
      dly_cnt_d   = 24'd0;
      delay_err_d = 1'b0;
    end else if (dly_cnt_q != DELAY_TIMEOUT) begin
      dly_cnt_d   = dly_cnt_q + 24'd1;
      delay_err_d = (dly_cnt_d == DELAY_TIMEOUT);
    end else begin
      dly_cnt_d   = dly_cnt_q;
      delay_err_d = 1'b1;
    end

    // After a timeout the next packet resynchronises the tick sequence.
    tick_vld_d = (delay_err_d && !delay_err_q) ? 1'b0 : tick_vld_upd_s;
  end

  // State and registered status outputs.
  always_ff @(posedge clk_125m or negedge rst_125m) begin
    if (!rst_125m) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= 11'd0;
      crc_q       <= CRC16_INIT;
      tick_q      <= 8'h00;
      last_tick_q <= 8'h00;
      tick_vld_q  <= 1'b0;
      rx_tick_q   <= 8'h00;
      dly_cnt_q   <= 24'd0;
      delay_err_q <= 1'b0;
      pkt_eop_q   <= 1'b0;
      len_err_q   <= 1'b0;
      tick_err_q  <= 1'b0;
      crc_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      crc_q       <= crc_d;
      tick_q      <= tick_d;
      last_tick_q <= last_tick_d;
      tick_vld_q  <= tick_vld_d;
      rx_tick_q   <= rx_tick_d;
      dly_cnt_q   <= dly_cnt_d;
      delay_err_q <= delay_err_d;
      pkt_eop_q   <= pkt_eop_d;
      len_err_q   <= len_err_d;
      tick_err_q  <= tick_err_d;
      crc_err_q   <= crc_err_d;
    end
  end

  assign chn_pkt_eop       = pkt_eop_q;
  assign chn_pkt_len_err   = len_err_q;
  assign chn_pkt_tick_err  = tick_err_q;
  assign chn_pkt_crc_err   = crc_err_q;
  assign chn_pkt_delay_err = delay_err_q;
  assign rx_pkt_tick       = rx_tick_q;

endmodule

// File: tb/tb_com_slink_pkt_check.sv
// Self-checking bench for com_slink_pkt_check: vector table, directed corner
// sequences and random traffic against a queue-based packet model.
module tb_com_slink_pkt_check;

  localparam logic [10:0] P_LEN = 11'd11;
  localparam logic [23:0] P_TO  = 24'd100;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic       v, s, e;
    logic [7:0] d;
    logic       x_eop, x_len, x_tick, x_crc;
    logic [7:0] x_rtick;
  } vec_t;

  logic       clk_125m = 1'b0;
  logic       rst_125m;
  logic [7:0] rx_data;
  logic       rx_valid, rx_sop, rx_eop;
  logic       chn_pkt_eop, chn_pkt_len_err, chn_pkt_tick_err, chn_pkt_crc_err;
  logic       chn_pkt_delay_err;
  logic [7:0] rx_pkt_tick;

  int n_vec = 0;
  int n_err = 0;

  // packet-level reference model state
  byte_q_t    m_pkt;
  bit         m_in_pkt;
  int         m_timer;
  bit         m_dly, m_tick_vld;
  logic [7:0] m_last_tick, m_rx_tick;
  bit         e_eop, e_len, e_tick, e_crc;

  com_slink_pkt_check #(.PKT_LEN(P_LEN), .DELAY_TIMEOUT(P_TO)) dut (
    .clk_125m          (clk_125m),
    .rst_125m          (rst_125m),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_sop            (rx_sop),
    .rx_eop            (rx_eop),
    .chn_pkt_eop       (chn_pkt_eop),
    .chn_pkt_len_err   (chn_pkt_len_err),
    .chn_pkt_tick_err  (chn_pkt_tick_err),
    .chn_pkt_crc_err   (chn_pkt_crc_err),
    .chn_pkt_delay_err (chn_pkt_delay_err),
    .rx_pkt_tick       (rx_pkt_tick)
  );

  always #4 clk_125m = ~clk_125m;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] crc16_q(input byte_q_t q);
    logic [15:0] c = 16'h0000;
    foreach (q[i]) begin
      c = c ^ {q[i], 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pkt.delete();
    m_in_pkt = 0; m_timer = 0; m_dly = 0; m_tick_vld = 0;
    m_last_tick = 8'h00; m_rx_tick = 8'h00;
    e_eop = 0; e_len = 0; e_tick = 0; e_crc = 0;
  endtask

  task automatic model_report();
    logic [7:0] tk;
    tk    = m_pkt[0];
    e_eop = 1;
    e_len = (m_pkt.size() != int'(P_LEN));
    e_crc = (crc16_q(m_pkt) != 16'h0000);
    e_tick = m_tick_vld && !e_crc && (tk != 8'(m_last_tick + 8'd1));
    if (!e_crc && !e_len) begin
      m_last_tick = tk; m_rx_tick = tk; m_tick_vld = 1;
    end
    m_pkt.delete();
    m_in_pkt = 0;
  endtask

  task automatic model_step(input logic v, input logic s, input logic e, input logic [7:0] d);
    e_eop = 0; e_len = 0; e_tick = 0; e_crc = 0;
    if (v) begin
      if (s) begin
        if (m_in_pkt) begin
          e_eop = 1; e_len = 1;
        end
        m_pkt.delete();
        m_pkt.push_back(d);
        m_in_pkt = 1;
        if (e && e_eop) begin
          m_pkt.delete(); m_in_pkt = 0;
        end else if (e) begin
          model_report();
        end
      end else if (m_in_pkt) begin
        m_pkt.push_back(d);
        if (e) model_report();
      end
    end
    if (e_eop) begin
      m_timer = 0; m_dly = 0;
    end else begin
      if (m_timer < int'(P_TO)) m_timer++;
      if (m_timer == int'(P_TO) && !m_dly) begin
        m_dly = 1; m_tick_vld = 0;
      end
    end
  endtask

  task automatic step(input logic v, input logic s, input logic e, input logic [7:0] d);
    rx_valid = v; rx_sop = s; rx_eop = e; rx_data = d;
    model_step(v, s, e, d);
    @(posedge clk_125m);
    #1;
    chk("eop",       {7'd0, chn_pkt_eop},       {7'd0, e_eop});
    chk("len_err",   {7'd0, chn_pkt_len_err},   {7'd0, e_len});
    chk("tick_err",  {7'd0, chn_pkt_tick_err},  {7'd0, e_tick});
    chk("crc_err",   {7'd0, chn_pkt_crc_err},   {7'd0, e_crc});
    chk("delay_err", {7'd0, chn_pkt_delay_err}, {7'd0, m_dly});
    chk("rx_pkt_tick", rx_pkt_tick, m_rx_tick);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic build_frame(input logic [7:0] tick, input int n, input int flip, output byte_q_t fr);
    logic [15:0] c;
    logic [7:0]  m;
    fr.delete();
    fr.push_back(tick);
    for (int i = 0; i < n - 3; i++) fr.push_back(8'($urandom));
    c = crc16_q(fr);
    fr.push_back(c[15:8]);
    fr.push_back(c[7:0]);
    if (flip >= 0) begin
      m = 8'h01 << (flip % 8);
      fr[1 + (flip / 8) % (n - 3)] = fr[1 + (flip / 8) % (n - 3)] ^ m;
    end
  endtask

  task automatic send_q(input byte_q_t fr, input int gap_pct);
    for (int i = 0; i < fr.size(); i++) begin
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct)
        step(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
      step(1'b1, i == 0, i == fr.size() - 1, fr[i]);
    end
  endtask

  task automatic send_frame(input logic [7:0] tick, input int n, input int flip);
    byte_q_t fr;
    build_frame(tick, n, flip, fr);
    send_q(fr, 0);
  endtask

  task automatic chk_status(input string nm, input logic l, input logic t, input logic c, input logic [7:0] rt);
    chk({nm, ".eop"},  {7'd0, chn_pkt_eop},      8'h01);
    chk({nm, ".len"},  {7'd0, chn_pkt_len_err},  {7'd0, l});
    chk({nm, ".tick"}, {7'd0, chn_pkt_tick_err}, {7'd0, t});
    chk({nm, ".crc"},  {7'd0, chn_pkt_crc_err},  {7'd0, c});
    chk({nm, ".rtick"}, rx_pkt_tick, rt);
  endtask

  task automatic do_reset();
    rst_125m = 1'b0;
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk_125m);
    #1;
    chk("rst.eop",   {7'd0, chn_pkt_eop},       8'h00);
    chk("rst.delay", {7'd0, chn_pkt_delay_err}, 8'h00);
    chk("rst.rtick", rx_pkt_tick,               8'h00);
    rst_125m = 1'b1;
    model_reset();
  endtask

  function automatic vec_t mkv(input logic v, input logic s, input logic e, input logic [7:0] d,
                               input logic xe, input logic xl, input logic xt, input logic xc,
                               input logic [7:0] xr);
    vec_t r;
    r.v = v; r.s = s; r.e = e; r.d = d;
    r.x_eop = xe; r.x_len = xl; r.x_tick = xt; r.x_crc = xc; r.x_rtick = xr;
    return r;
  endfunction

  vec_t tbl[16];

  initial begin
    byte_q_t fr;
    string   digits;
    digits = "123456789";

    tbl[0]  = mkv(1, 0, 0, 8'hAA, 0, 0, 0, 0, 8'h00);
    tbl[1]  = mkv(0, 1, 1, 8'h31, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) tbl[2 + i] = mkv(1, i == 0, 0, digits[i], 0, 0, 0, 0, 8'h00);
    tbl[11] = mkv(1, 0, 0, 8'h31, 0, 0, 0, 0, 8'h00);
    tbl[12] = mkv(1, 0, 1, 8'hC3, 1, 0, 0, 0, 8'h31);
    tbl[13] = mkv(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h31);
    tbl[14] = mkv(1, 1, 1, 8'h31, 1, 1, 0, 1, 8'h31);
    tbl[15] = mkv(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h31);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].d);
      chk("tbl.eop",   {7'd0, chn_pkt_eop},      {7'd0, tbl[i].x_eop});
      chk("tbl.len",   {7'd0, chn_pkt_len_err},  {7'd0, tbl[i].x_len});
      chk("tbl.tick",  {7'd0, chn_pkt_tick_err}, {7'd0, tbl[i].x_tick});
      chk("tbl.crc",   {7'd0, chn_pkt_crc_err},  {7'd0, tbl[i].x_crc});
      chk("tbl.rtick", rx_pkt_tick,              tbl[i].x_rtick);
    end

    // second good frame, then a corrupted one
    send_frame(8'h32, 11, -1);    chk_status("good32", 0, 0, 0, 8'h32);
    idle(1);
    send_frame(8'h33, 11, 13);    chk_status("flip",   0, 0, 1, 8'h32);

    // tick continuity and wrap
    do_reset();
    send_frame(8'h05, 11, -1);    chk_status("t05", 0, 0, 0, 8'h05);
    send_frame(8'h06, 11, -1);    chk_status("t06", 0, 0, 0, 8'h06);
    send_frame(8'h08, 11, -1);    chk_status("t08", 0, 1, 0, 8'h08);
    send_frame(8'hFF, 11, -1);    chk_status("tFF", 0, 1, 0, 8'hFF);
    send_frame(8'h00, 11, -1);    chk_status("t00", 0, 0, 0, 8'h00);

    // length errors and abort by a mid-frame sop
    send_frame(8'h01, 10, -1);    chk_status("len10", 1, 0, 0, 8'h00);
    send_frame(8'h01, 12, -1);    chk_status("len12", 1, 0, 0, 8'h00);
    step(1, 1, 0, 8'h55); step(1, 0, 0, 8'h01); step(0, 0, 0, 8'h00); step(1, 0, 0, 8'h02);
    build_frame(8'h01, 11, -1, fr);
    step(1, 1, 0, fr[0]);         chk_status("abort", 1, 0, 0, 8'h00);
    for (int i = 1; i < 11; i++) step(1, 0, i == 10, fr[i]);
    chk_status("after_abort", 0, 0, 0, 8'h01);
    step(1, 1, 0, 8'h02); step(1, 0, 0, 8'h03);
    step(1, 1, 1, 8'h04);         chk_status("abort_eop", 1, 0, 0, 8'h01);
    step(1, 0, 1, 8'h05);
    chk("drop.eop", {7'd0, chn_pkt_eop}, 8'h00);

    // delay timeout from reset, resync across a timeout
    do_reset();
    for (int i = 1; i <= 120; i++) begin
      step(0, 0, 0, 8'h00);
      if (i == 99)  chk("dly99",  {7'd0, chn_pkt_delay_err}, 8'h00);
      if (i == 100) chk("dly100", {7'd0, chn_pkt_delay_err}, 8'h01);
    end
    chk("dly_hold", {7'd0, chn_pkt_delay_err}, 8'h01);
    send_frame(8'h10, 11, -1);    chk_status("t10", 0, 0, 0, 8'h10);
    chk("dly_drop", {7'd0, chn_pkt_delay_err}, 8'h00);
    idle(110);
    chk("dly_again", {7'd0, chn_pkt_delay_err}, 8'h01);
    send_frame(8'h40, 11, -1);    chk_status("t40", 0, 0, 0, 8'h40);

    // asynchronous reset mid-packet
    build_frame(8'h41, 11, -1, fr);
    for (int i = 0; i < 5; i++) step(1, i == 0, 0, fr[i]);
    #2 rst_125m = 1'b0;
    rx_valid = 1'b0;
    #1;
    chk("arst.rtick", rx_pkt_tick,              8'h00);
    chk("arst.delay", {7'd0, chn_pkt_delay_err}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_125m); #1;
      chk("arst.eop", {7'd0, chn_pkt_eop}, 8'h00);
    end
    rst_125m = 1'b1;
    model_reset();
    idle(2);
    send_frame(8'h77, 11, -1);    chk_status("post_rst", 0, 0, 0, 8'h77);

    // random traffic against the model
    for (int it = 0; it < 300; it++) begin
      int kind;
      logic [7:0] tk;
      kind = int'($urandom_range(99));
      tk = ($urandom_range(99) < 70) ? 8'(m_last_tick + 8'd1) : 8'($urandom);
      if (kind < 60) begin
        build_frame(tk, 11, ($urandom_range(3) == 0) ? int'($urandom_range(63)) : -1, fr);
        send_q(fr, 20);
      end else if (kind < 75) begin
        build_frame(tk, int'($urandom_range(13, 9)), -1, fr);
        send_q(fr, 10);
      end else if (kind < 85) begin
        for (int i = 0; i < int'($urandom_range(6, 1)); i++)
          step(1'b1, i == 0, 1'b0, 8'($urandom));
      end else if (kind < 92) begin
        step(1'b1, 1'b0, 1'($urandom), 8'($urandom));
      end else begin
        idle(int'($urandom_range(130, 20)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
